// File: rtl/i2c_pwm_master.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_pwm_master
//  Description : Write-only I2C initiator: START, {addr,0}, two data bytes,
//                STOP, with the responder ACK checked after every byte.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_pwm_master #(
   parameter int QTR = 250
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [6:0] dev_addr,
   input  logic [7:0] data0,
   input  logic [7:0] data1,
   output logic       busy,
   output logic       done,
   output logic       ack_err,
   output logic       scl,
   inout  wire        sda
);

   localparam int              c_QW    = (QTR > 1) ? $clog2(QTR) : 1;
   localparam logic [c_QW-1:0] c_QLAST = c_QW'(QTR - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_BIT   = 3'd2,
      ST_ACK   = 3'd3,
      ST_STOP  = 3'd4
   } state_t;

   state_t          r_state,   w_state_nxt;
   logic [c_QW-1:0] r_qcnt,    w_qcnt_nxt;
   logic [1:0]      r_q,       w_q_nxt;
   logic [2:0]      r_bit,     w_bit_nxt;
   logic [1:0]      r_byte,    w_byte_nxt;
   logic [7:0]      r_sh,      w_sh_nxt;
   logic [7:0]      r_addr,    w_addr_nxt;
   logic [7:0]      r_d0,      w_d0_nxt;
   logic [7:0]      r_d1,      w_d1_nxt;
   logic            r_ack_err, w_ack_err_nxt;
   logic            r_done,    w_done_nxt;
   logic            r_scl;
   logic            r_sda_oe;
   logic            w_qend;
   logic            w_step_end;
   logic [1:0]      w_bus_nxt;

   // Bus levels for a given step/quarter, returned as {scl, sda_oe}
   function automatic logic [1:0] f_bus(input state_t st, input logic [1:0] q, input logic b);
      logic [1:0] f;
      f = 2'b10;
      case (st)
         ST_START: begin
            if (q == 2'd2)      f = 2'b11;
            else if (q == 2'd3) f = 2'b01;
            else                f = 2'b10;
         end
         ST_BIT:  f = {q[1], ~b};
         ST_ACK:  f = {q[1], 1'b0};
         ST_STOP: begin
            if (q == 2'd0)      f = 2'b01;
            else if (q == 2'd1) f = 2'b11;
            else                f = 2'b10;
         end
         default: f = 2'b10;
      endcase
      return f;
   endfunction

   assign w_qend     = (r_qcnt == c_QLAST);
   assign w_step_end = w_qend && (r_q == 2'd3);

   always_comb begin
      w_state_nxt   = r_state;
      w_qcnt_nxt    = r_qcnt;
      w_q_nxt       = r_q;
      w_bit_nxt     = r_bit;
      w_byte_nxt    = r_byte;
      w_sh_nxt      = r_sh;
      w_addr_nxt    = r_addr;
      w_d0_nxt      = r_d0;
      w_d1_nxt      = r_d1;
      w_ack_err_nxt = r_ack_err;
      w_done_nxt    = 1'b0;

      if (r_state == ST_IDLE) begin
         if (start) begin
            w_addr_nxt    = {dev_addr, 1'b0};
            w_d0_nxt      = data0;
            w_d1_nxt      = data1;
            w_ack_err_nxt = 1'b0;
            w_byte_nxt    = 2'd0;
            w_qcnt_nxt    = '0;
            w_q_nxt       = 2'd0;
            w_state_nxt   = ST_START;
         end
      end else begin
         if (w_qend) begin
            w_qcnt_nxt = '0;
            w_q_nxt    = r_q + 2'd1;
         end else begin
            w_qcnt_nxt = r_qcnt + 1'b1;
         end

         // Responder ACK is sampled on the final clock of ACK Q2
         if (r_state == ST_ACK && r_q == 2'd2 && w_qend && sda != 1'b0)
            w_ack_err_nxt = 1'b1;

         if (w_step_end) begin
            case (r_state)
               ST_START: begin
                  w_state_nxt = ST_BIT;
                  w_bit_nxt   = 3'd7;
                  w_sh_nxt    = r_addr;
               end
               ST_BIT: begin
                  if (r_bit == 3'd0) begin
                     w_state_nxt = ST_ACK;
                  end else begin
                     w_bit_nxt = r_bit - 3'd1;
                     w_sh_nxt  = {r_sh[6:0], 1'b0};
                  end
               end
               ST_ACK: begin
                  if (r_ack_err || r_byte == 2'd2) begin
                     w_state_nxt = ST_STOP;
                  end else begin
                     w_byte_nxt  = r_byte + 2'd1;
                     w_state_nxt = ST_BIT;
                     w_bit_nxt   = 3'd7;
                     w_sh_nxt    = (r_byte == 2'd0) ? r_d0 : r_d1;
                  end
               end
               ST_STOP: begin
                  w_state_nxt = ST_IDLE;
                  w_done_nxt  = 1'b1;
               end
               default: w_state_nxt = ST_IDLE;
            endcase
         end
      end
   end

   // Bus pins are registered from the next-step values so they switch cleanly
   assign w_bus_nxt = f_bus(w_state_nxt, w_q_nxt, w_sh_nxt[7]);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= ST_IDLE;
         r_qcnt    <= '0;
         r_q       <= 2'd0;
         r_bit     <= 3'd0;
         r_byte    <= 2'd0;
         r_sh      <= 8'd0;
         r_addr    <= 8'd0;
         r_d0      <= 8'd0;
         r_d1      <= 8'd0;
         r_ack_err <= 1'b0;
         r_done    <= 1'b0;
         r_scl     <= 1'b1;
         r_sda_oe  <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_qcnt    <= w_qcnt_nxt;
         r_q       <= w_q_nxt;
         r_bit     <= w_bit_nxt;
         r_byte    <= w_byte_nxt;
         r_sh      <= w_sh_nxt;
         r_addr    <= w_addr_nxt;
         r_d0      <= w_d0_nxt;
         r_d1      <= w_d1_nxt;
         r_ack_err <= w_ack_err_nxt;
         r_done    <= w_done_nxt;
         r_scl     <= w_bus_nxt[1];
         r_sda_oe  <= w_bus_nxt[0];
      end
   end

   assign busy    = (r_state != ST_IDLE);
   assign done    = r_done;
   assign ack_err = r_ack_err;
   assign scl     = r_scl;
   assign sda     = r_sda_oe ? 1'b0 : 1'bz;

endmodule
`default_nettype wire

// File: tb/tb_i2c_pwm_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_pwm_master
//  Description : Directed bench for i2c_pwm_master with a bus-level responder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_pwm_master;

   localparam int QTR = 4;

   logic       clk      = 1'b0;
   logic       rst      = 1'b0;
   logic       start    = 1'b0;
   logic [6:0] dev_addr = 7'd0;
   logic [7:0] data0    = 8'd0;
   logic [7:0] data1    = 8'd0;
   logic       busy;
   logic       done;
   logic       ack_err;
   logic       scl;
   wire        sda;
   logic       tb_drv   = 1'b0;

   pullup (sda);
   assign sda = tb_drv ? 1'b0 : 1'bz;

   i2c_pwm_master #(.QTR(QTR)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .dev_addr (dev_addr),
      .data0    (data0),
      .data1    (data1),
      .busy     (busy),
      .done     (done),
      .ack_err  (ack_err),
      .scl      (scl),
      .sda      (sda)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Responder model: decodes bytes on scl rise, ACKs unless byte index == nack_idx
   int         starts = 0, stops = 0, nb = 0, bitc = 0, frame_byte = 0;
   int         nack_idx = 3;
   logic [7:0] seen [0:63];
   logic [7:0] msh = 8'd0;
   logic       in_ack = 1'b0, p_scl = 1'b1, p_sda = 1'b1;

   always @(negedge clk) begin : mon
      logic s;
      s = (sda === 1'b0) ? 1'b0 : 1'b1;
      if (!rst) begin
         bitc = 0; in_ack = 1'b0; tb_drv = 1'b0; p_scl = 1'b1; p_sda = 1'b1;
      end else begin
         if (p_scl && scl && p_sda && !s) begin
            starts++; bitc = 0; frame_byte = 0; in_ack = 1'b0;
         end else if (p_scl && scl && !p_sda && s) begin
            stops++;
         end else if (!p_scl && scl) begin
            if (!in_ack) begin
               msh = {msh[6:0], s};
               bitc++;
               if (bitc == 8) begin
                  seen[nb % 64] = msh;
                  nb++;
               end
            end
         end else if (p_scl && !scl) begin
            if (in_ack) begin
               in_ack = 1'b0; tb_drv = 1'b0;
            end else if (bitc == 8) begin
               in_ack = 1'b1; bitc = 0;
               tb_drv = (frame_byte != nack_idx);
               frame_byte++;
            end
         end
         p_scl = scl; p_sda = s;
      end
   end

   int n_cmp = 0, n_fail = 0;
   int e_cyc = 0, b_nb = 0, b_starts = 0, b_stops = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic snap();
      b_nb = nb; b_starts = starts; b_stops = stops;
   endtask

   task automatic launch(input logic [6:0] a, input logic [7:0] d0, input logic [7:0] d1);
      @(negedge clk);
      snap();
      dev_addr = a; data0 = d0; data1 = d1; start = 1'b1;
      e_cyc = cyc + 1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_accept", {31'd0, busy}, 32'd1);
      chk("ack_err_cleared", {31'd0, ack_err}, 32'd0);
   endtask

   task automatic wait_done(output int lat);
      lat = -1;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (done) begin
            lat = cyc - e_cyc;
            break;
         end
      end
   endtask

   task automatic check_txn(input int lat, input int exp_lat, input logic exp_err,
                            input int exp_nb, input logic [7:0] x0, input logic [7:0] x1,
                            input logic [7:0] x2);
      logic [7:0] xb [3];
      xb[0] = x0; xb[1] = x1; xb[2] = x2;
      chk("done_latency", lat, exp_lat);
      chk("busy_low_at_done", {31'd0, busy}, 32'd0);
      chk("ack_err_at_done", {31'd0, ack_err}, {31'd0, exp_err});
      chk("byte_count", nb - b_nb, exp_nb);
      for (int k = 0; k < exp_nb; k++)
         chk($sformatf("byte%0d", k), {24'd0, seen[(b_nb + k) % 64]}, {24'd0, xb[k]});
      chk("start_count", starts - b_starts, 1);
      chk("stop_count", stops - b_stops, 1);
   endtask

   typedef struct {
      logic [6:0] a;
      logic [7:0] d0;
      logic [7:0] d1;
      int         nack;
      int         nbytes;
      logic [7:0] b0;
      logic [7:0] b1;
      logic [7:0] b2;
      int         lat;
      logic       err;
   } vec_t;

   vec_t v [5];

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int lat;
      v[0] = '{7'h42, 8'hAB, 8'h40, 3, 3, 8'h84, 8'hAB, 8'h40, 464, 1'b0};
      v[1] = '{7'h42, 8'hAB, 8'h40, 0, 1, 8'h84, 8'h00, 8'h00, 176, 1'b1};
      v[2] = '{7'h42, 8'h12, 8'h34, 1, 2, 8'h84, 8'h12, 8'h00, 320, 1'b1};
      v[3] = '{7'h7F, 8'hFF, 8'h00, 2, 3, 8'hFE, 8'hFF, 8'h00, 464, 1'b1};
      v[4] = '{7'h00, 8'h00, 8'hFF, 3, 3, 8'h00, 8'h00, 8'hFF, 464, 1'b0};

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_scl", {31'd0, scl}, 32'd1);
      chk("rst_sda", {31'd0, sda}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_ack_err", {31'd0, ack_err}, 32'd0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 5; i++) begin
         nack_idx = v[i].nack;
         launch(v[i].a, v[i].d0, v[i].d1);
         wait_done(lat);
         check_txn(lat, v[i].lat, v[i].err, v[i].nbytes, v[i].b0, v[i].b1, v[i].b2);
         @(negedge clk);
         chk("done_one_cycle", {31'd0, done}, 32'd0);
         repeat (4) @(negedge clk);
      end

      // start pulse and data1 change mid-transfer must be ignored
      nack_idx = 3;
      launch(7'h42, 8'hAB, 8'h40);
      repeat (50) @(negedge clk);
      start = 1'b1; data1 = 8'hFF;
      @(negedge clk);
      start = 1'b0;
      wait_done(lat);
      check_txn(lat, 464, 1'b0, 3, 8'h84, 8'hAB, 8'h40);
      repeat (600) @(negedge clk);
      chk("ignore_no_second_txn", starts - b_starts, 1);
      chk("ignore_idle_busy", {31'd0, busy}, 32'd0);

      // Asynchronous reset mid-byte releases the bus at once, no STOP
      launch(7'h42, 8'hAB, 8'h40);
      repeat (100) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("midrst_scl", {31'd0, scl}, 32'd1);
      chk("midrst_sda", {31'd0, sda}, 32'd1);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      repeat (3) @(negedge clk);
      chk("midrst_no_stop", stops - b_stops, 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      launch(7'h42, 8'hAB, 8'h40);
      wait_done(lat);
      check_txn(lat, 464, 1'b0, 3, 8'h84, 8'hAB, 8'h40);
      repeat (4) @(negedge clk);

      // Back-to-back: start held through done, NACKed first then clean second
      nack_idx = 0;
      @(negedge clk);
      snap();
      dev_addr = 7'h42; data0 = 8'hAB; data1 = 8'h40; start = 1'b1;
      e_cyc = cyc + 1;
      @(negedge clk);
      chk("b2b_busy1", {31'd0, busy}, 32'd1);
      wait_done(lat);
      check_txn(lat, 176, 1'b1, 1, 8'h84, 8'h00, 8'h00);
      chk("b2b_start_held", {31'd0, start}, 32'd1);
      nack_idx = 3;
      snap();
      e_cyc = cyc + 1;
      @(negedge clk);
      start = 1'b0;
      chk("b2b_busy2", {31'd0, busy}, 32'd1);
      chk("b2b_ack_err_clr", {31'd0, ack_err}, 32'd0);
      chk("b2b_done_low", {31'd0, done}, 32'd0);
      wait_done(lat);
      check_txn(lat, 464, 1'b0, 3, 8'h84, 8'hAB, 8'h40);
      repeat (4) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
